// File: rtl/id_queue_pkg.sv
// RV32I decode types shared by the instruction queue, its interface and the decoder.
// Holds the opcode/funct3 enums, ALU/compare encodings, the decoded uop and immediate helpers.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode_t;

    typedef enum logic [2:0] {
        f3_add  = 3'b000,
        f3_sll  = 3'b001,
        f3_slt  = 3'b010,
        f3_sltu = 3'b011,
        f3_xor  = 3'b100,
        f3_sr   = 3'b101,
        f3_or   = 3'b110,
        f3_and  = 3'b111
    } arith_f3_t;

    // Compare encodings reuse the branch funct3 so BR can pass funct3 straight through.
    typedef enum logic [2:0] {
        cmp_beq  = 3'b000,
        cmp_bne  = 3'b001,
        cmp_blt  = 3'b100,
        cmp_bge  = 3'b101,
        cmp_bltu = 3'b110,
        cmp_bgeu = 3'b111
    } cmp_op_t;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic    alu_or_cmp;
        alu_op_t aluop;
        cmp_op_t cmpop;
    } alu_sel_t;

    // One instruction-buffer slot as delivered by fetch.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pred_pc;
        logic        pred_taken;
    } ib_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pred_pc;
        logic        pred_taken;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd_s;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [31:0] rs1_v;
        logic [31:0] rs2_v;
        logic [31:0] imm;
        logic        use_imm;
        logic        regf_we;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
        logic        alu_or_cmp;
        alu_op_t     aluop;
        cmp_op_t     cmpop;
    } decoded_uop_t;

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{21{inst[31]}}, inst[30:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{21{inst[31]}}, inst[30:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'h000};
    endfunction

    // SLT/SLTU go to the comparator; funct7[5] picks SUB only for register ADD, SRA for both shift forms.
    function automatic alu_sel_t alu_select(input logic [2:0] funct3, input logic funct7_b5,
                                            input logic is_reg);
        alu_sel_t s;
        s.alu_or_cmp = 1'b1;
        s.aluop      = alu_add;
        s.cmpop      = cmp_beq;
        case (arith_f3_t'(funct3))
            f3_add:  s.aluop = (is_reg && funct7_b5) ? alu_sub : alu_add;
            f3_sll:  s.aluop = alu_sll;
            f3_slt:  begin s.alu_or_cmp = 1'b0; s.cmpop = cmp_blt;  end
            f3_sltu: begin s.alu_or_cmp = 1'b0; s.cmpop = cmp_bltu; end
            f3_xor:  s.aluop = alu_xor;
            f3_sr:   s.aluop = funct7_b5 ? alu_sra : alu_srl;
            f3_or:   s.aluop = alu_or;
            f3_and:  s.aluop = alu_and;
            default: s.aluop = alu_add;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/id_queue_if.sv
// Fetch-side push channel and execute-side pop channel of the instruction queue.
interface id_queue_if;
    import rv32i_types::*;

    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_pc;
    logic [31:0]  in_inst;
    logic [31:0]  in_pred_pc;
    logic         in_pred_taken;
    logic         out_valid;
    logic         out_ready;
    decoded_uop_t out_uop;

    // master is the surrounding pipeline (fetch + execute); slave is the queue itself.
    modport master (
        output in_valid, in_pc, in_inst, in_pred_pc, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_uop
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_pred_pc, in_pred_taken, out_ready,
        output in_ready, out_valid, out_uop
    );
endinterface

// File: rtl/id_queue_inst_decoder.sv
// Combinational RV32I decoder applied to the head entry of the instruction queue.
// Source values are left zero here; the queue fills them from the regfile/bypass network.
module inst_decoder
    import rv32i_types::*;
(
    input  ib_entry_t    entry,
    output decoded_uop_t uop
);

    logic [31:0] inst;
    logic [2:0]  funct3;
    alu_sel_t    sel;

    assign inst   = entry.inst;
    assign funct3 = inst[14:12];
    assign sel    = alu_select(funct3, inst[30], inst[6:0] == op_reg);

    always_comb begin
        // NOTE: the whole uop is defaulted before the case, so no opcode path can leave a field
        // unassigned and infer a latch; it also makes unknown opcodes inert by construction.
        uop            = '0;
        uop.pc         = entry.pc;
        uop.inst       = inst;
        uop.pred_pc    = entry.pred_pc;
        uop.pred_taken = entry.pred_taken;
        uop.opcode     = inst[6:0];
        uop.funct3     = funct3;
        uop.rd_s       = inst[11:7];
        uop.rs1_s      = inst[19:15];
        uop.rs2_s      = inst[24:20];
        uop.alu_or_cmp = 1'b1;
        uop.aluop      = alu_add;
        uop.cmpop      = cmp_beq;

        case (rv32i_opcode_t'(inst[6:0]))
            op_lui, op_auipc: begin
                uop.regf_we = 1'b1;
                uop.use_imm = 1'b1;
                uop.imm     = imm_u(inst);
                uop.rs1_s   = '0;
                uop.rs2_s   = '0;
            end
            op_jal: begin
                uop.regf_we = 1'b1;
                uop.jal     = 1'b1;
                uop.use_imm = 1'b1;
                uop.imm     = 32'd4;
                uop.rs1_s   = '0;
                uop.rs2_s   = '0;
            end
            op_jalr: begin
                uop.regf_we = 1'b1;
                uop.jalr    = 1'b1;
                uop.use_imm = 1'b1;
                uop.imm     = 32'd4;
                uop.rs2_s   = '0;
            end
            op_br: begin
                uop.branch     = 1'b1;
                uop.imm        = imm_b(inst);
                uop.rd_s       = '0;
                uop.alu_or_cmp = 1'b0;
                uop.cmpop      = cmp_op_t'(funct3);
            end
            op_load: begin
                uop.regf_we  = 1'b1;
                uop.mem_read = 1'b1;
                uop.use_imm  = 1'b1;
                uop.imm      = imm_i(inst);
                uop.rs2_s    = '0;
            end
            op_store: begin
                uop.mem_write = 1'b1;
                uop.use_imm   = 1'b1;
                uop.imm       = imm_s(inst);
                uop.rd_s      = '0;
            end
            op_imm: begin
                uop.regf_we    = 1'b1;
                uop.use_imm    = 1'b1;
                uop.rs2_s      = '0;
                // Shift immediates carry funct7 in the upper bits, so only the shamt is kept.
                uop.imm        = (funct3 == f3_sll || funct3 == f3_sr) ?
                                 {27'd0, inst[24:20]} : imm_i(inst);
                uop.alu_or_cmp = sel.alu_or_cmp;
                uop.aluop      = sel.aluop;
                uop.cmpop      = sel.cmpop;
            end
            op_reg: begin
                uop.regf_we    = 1'b1;
                uop.alu_or_cmp = sel.alu_or_cmp;
                uop.aluop      = sel.aluop;
                uop.cmpop      = sel.cmpop;
            end
            default: begin
                uop.illegal = 1'b1;
                uop.rd_s    = '0;
                uop.rs1_s   = '0;
                uop.rs2_s   = '0;
            end
        endcase
    end

endmodule

// File: rtl/id_queue.sv
// Instruction buffer between fetch and execute: a DEPTH-entry circular queue whose head is
// decoded combinationally, with regfile source values bypassed from the writeback ports.
module id_queue
    import rv32i_types::*;
#(
    parameter int DEPTH  = 4,
    parameter int NUM_WB = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    id_queue_if.slave                    bus,
    output logic [4:0]                   rf_rs1_s,
    output logic [4:0]                   rf_rs2_s,
    input  logic [31:0]                  rf_rs1_v,
    input  logic [31:0]                  rf_rs2_v,
    input  logic [NUM_WB-1:0]            wb_we,
    input  logic [NUM_WB-1:0][4:0]       wb_rd_s,
    input  logic [NUM_WB-1:0][31:0]      wb_rd_v,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    ib_entry_t        mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             push;
    logic             pop;
    ib_entry_t        in_entry;
    ib_entry_t        head;
    decoded_uop_t     dec_uop;
    logic [31:0]      rs1_val;
    logic [31:0]      rs2_val;

    // Both handshakes depend only on the registered count (plus flush), never on out_ready.
    assign bus.in_ready  = (count < FULL);
    assign bus.out_valid = (count != '0) && !flush;

    assign push = bus.in_valid && bus.in_ready && !flush;
    assign pop  = bus.out_valid && bus.out_ready;

    assign in_entry = '{pc: bus.in_pc, inst: bus.in_inst,
                        pred_pc: bus.in_pred_pc, pred_taken: bus.in_pred_taken};

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every reader of wptr/rptr/count
        // in this edge sees the pre-edge values regardless of statement order.
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the payload array has no reset; validity is tracked entirely by count, and leaving
    // the storage unreset lets it map onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_entry;
    end

    assign head = mem[rptr];

    inst_decoder u_decoder (
        .entry (head),
        .uop   (dec_uop)
    );

    assign rf_rs1_s = dec_uop.rs1_s;
    assign rf_rs2_s = dec_uop.rs2_s;

    // Later writeback ports override earlier ones; x0 is forced to zero last so nothing can beat it.
    always_comb begin
        rs1_val = rf_rs1_v;
        rs2_val = rf_rs2_v;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_we[i] && wb_rd_s[i] == dec_uop.rs1_s) rs1_val = wb_rd_v[i];
            if (wb_we[i] && wb_rd_s[i] == dec_uop.rs2_s) rs2_val = wb_rd_v[i];
        end
        if (dec_uop.rs1_s == '0) rs1_val = '0;
        if (dec_uop.rs2_s == '0) rs2_val = '0;
    end

    always_comb begin
        bus.out_uop       = dec_uop;
        bus.out_uop.rs1_v = rs1_val;
        bus.out_uop.rs2_v = rs2_val;
    end

endmodule

// File: tb/tb_id_queue.sv
// Directed bench for id_queue: a decode vector table plus hand-written sequences for
// fill, streaming, flush, bypass and asynchronous reset.
module tb_id_queue;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [4:0]        rf_rs1_s;
    logic [4:0]        rf_rs2_s;
    logic [31:0]       rf_rs1_v;
    logic [31:0]       rf_rs2_v;
    logic [1:0]        wb_we;
    logic [1:0][4:0]   wb_rd_s;
    logic [1:0][31:0]  wb_rd_v;
    logic [2:0]        count;

    int n_cmp  = 0;
    int n_fail = 0;

    id_queue_if bus ();

    id_queue #(.DEPTH(4), .NUM_WB(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus),
        .rf_rs1_s (rf_rs1_s),
        .rf_rs2_s (rf_rs2_s),
        .rf_rs1_v (rf_rs1_v),
        .rf_rs2_v (rf_rs2_v),
        .wb_we    (wb_we),
        .wb_rd_s  (wb_rd_s),
        .wb_rd_v  (wb_rd_v),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        imm_care;
        logic [31:0] imm;
        logic [6:0]  flags;   // {regf_we, mem_read, mem_write, branch, jal, jalr, illegal}
        logic        op_care;
        logic        aoc;
        logic [2:0]  op;      // aluop when aoc = 1, cmpop when aoc = 0
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_flags;
        int          next_push;
        int          next_pop;

        vecs[0]  = '{"sw",    32'h0020A423, 5'd0, 5'd1, 5'd2,  1'b1, 32'd8,        7'b0010000, 1'b0, 1'b1, 3'd0};
        vecs[1]  = '{"srai",  32'h4030D093, 5'd1, 5'd1, 5'd0,  1'b1, 32'd3,        7'b1000000, 1'b1, 1'b1, 3'b010};
        vecs[2]  = '{"ill7f", 32'h0000007F, 5'd0, 5'd0, 5'd0,  1'b0, 32'd0,        7'b0000001, 1'b0, 1'b1, 3'd0};
        vecs[3]  = '{"lui",   32'h123453B7, 5'd7, 5'd0, 5'd0,  1'b1, 32'h12345000, 7'b1000000, 1'b0, 1'b1, 3'd0};
        vecs[4]  = '{"jal",   32'h008000EF, 5'd1, 5'd0, 5'd0,  1'b1, 32'd4,        7'b1000100, 1'b0, 1'b1, 3'd0};
        vecs[5]  = '{"jalr",  32'h00008067, 5'd0, 5'd1, 5'd0,  1'b1, 32'd4,        7'b1000010, 1'b0, 1'b1, 3'd0};
        vecs[6]  = '{"bne",   32'h00419863, 5'd0, 5'd3, 5'd4,  1'b1, 32'd16,       7'b0001000, 1'b1, 1'b0, 3'b001};
        vecs[7]  = '{"slti",  32'hFFF12313, 5'd6, 5'd2, 5'd0,  1'b1, 32'hFFFFFFFF, 7'b1000000, 1'b1, 1'b0, 3'b100};
        vecs[8]  = '{"sub",   32'h40A48433, 5'd8, 5'd9, 5'd10, 1'b0, 32'd0,        7'b1000000, 1'b1, 1'b1, 3'b011};
        vecs[9]  = '{"lw",    32'hFF82A203, 5'd4, 5'd5, 5'd0,  1'b1, 32'hFFFFFFF8, 7'b1100000, 1'b0, 1'b1, 3'd0};
        vecs[10] = '{"auipc", 32'h00001197, 5'd3, 5'd0, 5'd0,  1'b1, 32'h00001000, 7'b1000000, 1'b0, 1'b1, 3'd0};

        rst               = 1'b0;
        flush             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_pc         = '0;
        bus.in_inst       = 32'h00000013;
        bus.in_pred_pc    = '0;
        bus.in_pred_taken = 1'b0;
        bus.out_ready     = 1'b0;
        rf_rs1_v          = 32'hAAAA0001;
        rf_rs2_v          = 32'hBBBB0002;
        wb_we             = '0;
        wb_rd_s           = '0;
        wb_rd_v           = '0;

        // Reset state
        #1;
        check("rst.count",     32'(count),         32'd0);
        check("rst.in_ready",  32'(bus.in_ready),  32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        step();
        step();
        rst = 1'b1;
        step();

        // Decode table: push one entry, check the head, pop it
        for (int k = 0; k < NV; k++) begin
            exp_pc            = 32'h100 + 32'(k) * 32'd16;
            bus.in_inst       = vecs[k].inst;
            bus.in_pc         = exp_pc;
            bus.in_pred_pc    = exp_pc + 32'h40;
            bus.in_pred_taken = k[0];
            bus.in_valid      = 1'b1;
            step();
            bus.in_valid = 1'b0;
            #1;
            exp_flags = {25'd0, vecs[k].flags};
            check({vecs[k].name, ".valid"}, 32'(bus.out_valid), 32'd1);
            check({vecs[k].name, ".pc"}, bus.out_uop.pc, exp_pc);
            check({vecs[k].name, ".pred_pc"}, bus.out_uop.pred_pc, exp_pc + 32'h40);
            check({vecs[k].name, ".pred_taken"}, 32'(bus.out_uop.pred_taken), 32'(k[0]));
            check({vecs[k].name, ".rd"}, 32'(bus.out_uop.rd_s), 32'(vecs[k].rd));
            check({vecs[k].name, ".rs1_s"}, 32'(rf_rs1_s), 32'(vecs[k].rs1));
            check({vecs[k].name, ".rs2_s"}, 32'(rf_rs2_s), 32'(vecs[k].rs2));
            check({vecs[k].name, ".rs1_v"}, bus.out_uop.rs1_v,
                  (vecs[k].rs1 == 5'd0) ? 32'd0 : 32'hAAAA0001);
            check({vecs[k].name, ".rs2_v"}, bus.out_uop.rs2_v,
                  (vecs[k].rs2 == 5'd0) ? 32'd0 : 32'hBBBB0002);
            check({vecs[k].name, ".flags"},
                  32'({bus.out_uop.regf_we, bus.out_uop.mem_read, bus.out_uop.mem_write,
                       bus.out_uop.branch, bus.out_uop.jal, bus.out_uop.jalr,
                       bus.out_uop.illegal}), exp_flags);
            if (vecs[k].imm_care)
                check({vecs[k].name, ".imm"}, bus.out_uop.imm, vecs[k].imm);
            if (vecs[k].op_care) begin
                check({vecs[k].name, ".aoc"}, 32'(bus.out_uop.alu_or_cmp), 32'(vecs[k].aoc));
                check({vecs[k].name, ".op"},
                      vecs[k].aoc ? 32'(bus.out_uop.aluop) : 32'(bus.out_uop.cmpop),
                      32'(vecs[k].op));
            end
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            check({vecs[k].name, ".popped"}, 32'(count), 32'd0);
        end

        // Fill to DEPTH with the consumer stalled, then offer a fifth entry
        bus.in_inst = 32'h00000013;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_pc    = 32'h2000 + 32'(i) * 32'd4;
            if (i == 0) begin
                #1;
                check("fill.no_bypass", 32'(bus.out_valid), 32'd0);
            end
            step();
            check("fill.count", 32'(count), 32'(i + 1));
        end
        check("fill.in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_pc = 32'h2010;
        step();
        check("fill.fifth_count", 32'(count), 32'd4);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain.pc", bus.out_uop.pc, 32'h2000 + 32'(i) * 32'd4);
            step();
        end
        check("drain.count", 32'(count), 32'd0);
        check("drain.out_valid", 32'(bus.out_valid), 32'd0);

        // Streaming: push and pop every cycle
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h3000;
        step();
        next_push = 1;
        next_pop  = 0;
        for (int i = 0; i < 20; i++) begin
            check("stream.count", 32'(count), 32'd1);
            check("stream.valid", 32'(bus.out_valid), 32'd1);
            check("stream.pc", bus.out_uop.pc, 32'h3000 + 32'(next_pop) * 32'd4);
            bus.in_pc = 32'h3000 + 32'(next_push) * 32'd4;
            step();
            next_push++;
            next_pop++;
        end
        bus.in_valid = 1'b0;
        check("stream.last_pc", bus.out_uop.pc, 32'h3000 + 32'(next_pop) * 32'd4);
        step();
        check("stream.end_count", 32'(count), 32'd0);
        bus.out_ready = 1'b0;

        // Flush with three entries, a push and a pop request in the same cycle
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_pc    = 32'h4000 + 32'(i) * 32'd4;
            step();
        end
        check("flush.pre_count", 32'(count), 32'd3);
        flush         = 1'b1;
        bus.in_pc     = 32'hDEAD0000;
        bus.out_ready = 1'b1;
        #1;
        check("flush.valid_during", 32'(bus.out_valid), 32'd0);
        step();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("flush.count", 32'(count), 32'd0);
        check("flush.out_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h5000;
        step();
        bus.in_valid = 1'b0;
        check("flush.after_count", 32'(count), 32'd1);
        check("flush.after_pc", bus.out_uop.pc, 32'h5000);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Bypass: add x5,x3,x3 at the head
        bus.in_inst  = 32'h003182B3;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        rf_rs1_v     = 32'h33;
        rf_rs2_v     = 32'h44;
        wb_we        = 2'b11;
        wb_rd_s[0]   = 5'd3;
        wb_rd_s[1]   = 5'd3;
        wb_rd_v[0]   = 32'h11;
        wb_rd_v[1]   = 32'h22;
        #1;
        check("byp.rf_rs1_s", 32'(rf_rs1_s), 32'd3);
        check("byp.both.rs1", bus.out_uop.rs1_v, 32'h22);
        check("byp.both.rs2", bus.out_uop.rs2_v, 32'h22);
        wb_we = 2'b01;
        #1;
        check("byp.wb0.rs1", bus.out_uop.rs1_v, 32'h11);
        wb_we = 2'b00;
        #1;
        check("byp.rf.rs1", bus.out_uop.rs1_v, 32'h33);
        check("byp.rf.rs2", bus.out_uop.rs2_v, 32'h44);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // x0 sources: add x5,x0,x0 with writebacks targeting x0
        bus.in_inst  = 32'h000002B3;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wb_we        = 2'b11;
        wb_rd_s[0]   = 5'd0;
        wb_rd_s[1]   = 5'd0;
        wb_rd_v[0]   = 32'h55;
        wb_rd_v[1]   = 32'h66;
        rf_rs1_v     = 32'h77;
        rf_rs2_v     = 32'h88;
        #1;
        check("x0.rs1", bus.out_uop.rs1_v, 32'd0);
        check("x0.rs2", bus.out_uop.rs2_v, 32'd0);
        wb_we         = 2'b00;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Asynchronous reset in the middle of a cycle with two entries held
        bus.in_inst  = 32'h00000013;
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h6000;
        step();
        bus.in_pc = 32'h6004;
        step();
        bus.in_valid = 1'b0;
        check("arst.pre_count", 32'(count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("arst.count", 32'(count), 32'd0);
        check("arst.out_valid", 32'(bus.out_valid), 32'd0);
        check("arst.in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b1;
        step();
        check("arst.post_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_queue.md
ID_QUEUE -- requirements
Module: id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter NUM_WB, default 2, writeback bypass ports.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  in  1  discard all buffered instructions.
REQ-006 SHALL have port in_valid  in  1  fetch offers an instruction.
REQ-007 SHALL have port in_ready  out  1  buffer accepts an instruction.
REQ-008 SHALL have ports in_pc, in_inst, in_pred_pc  in  32 each  fetch payload.
REQ-009 SHALL have port in_pred_taken  in  1  branch-predictor direction.
REQ-010 SHALL have port out_valid  out  1  decoded uop available.
REQ-011 SHALL have port out_ready  in  1  execute consumes the uop.
REQ-012 SHALL have port out_uop  out  decoded_uop_t  decoded fields of the head entry.
REQ-013 SHALL have ports rf_rs1_s, rf_rs2_s  out  5 each  regfile read addresses.
REQ-014 SHALL have ports rf_rs1_v, rf_rs2_v  in  32 each  regfile read data.
REQ-015 SHALL have ports wb_we  in  NUM_WB, wb_rd_s  in  NUM_WB x 5, wb_rd_v  in  NUM_WB x 32  writeback ports.
REQ-016 SHALL have port count  out  $clog2(DEPTH)+1  occupancy.

Function
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL be 1 iff count < DEPTH, from registered state only; no combinational path from out_ready.
REQ-019 out_valid SHALL be 1 iff count != 0 and flush == 0.
REQ-020 Latency: an entry pushed at edge t SHALL be visible at the output in cycle t+1; no same-cycle bypass from input to output.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, with both pointers advancing.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 flush SHALL zero count and both pointers at the next edge; a push in the flush cycle SHALL be discarded, and the flush takes priority over a pop.
REQ-024 Decode of the head entry SHALL be combinational.
REQ-025 Unused source registers SHALL read as address 0: LUI/AUIPC/JAL use neither; JALR/LOAD/IMM use rs1 only.
REQ-026 STORE and BRANCH SHALL report rd = 0 and regf_we = 0.
REQ-027 Immediate selection: U for LUI/AUIPC; 4 for JAL/JALR; B for BR; I for LOAD/IMM; S for STORE.
REQ-028 The SRAI/SRLI shamt SHALL be inst[24:20] zero-extended.
REQ-029 ALU op: SLT/SLTU SHALL map to cmp blt/bltu with alu_or_cmp = 0; funct7[5] SHALL select SUB for OP-ADD and SRA for shifts.
REQ-030 An unknown opcode SHALL set illegal = 1 and force regf_we, mem_read, mem_write, branch, jal and jalr to 0.
REQ-031 rs values SHALL be bypassed from wb ports: the highest-index port with wb_we && wb_rd_s == rs && rs != 0 wins; otherwise the value comes from rf_rs*_v.
REQ-032 Source register x0 SHALL always read 0, regardless of regfile or bypass.
REQ-033 out_uop SHALL carry pc, pred_taken and pred_pc unchanged from the entry.
REQ-034 When out_valid = 0, out_uop SHALL hold its decode of the stale head; consumers qualify it with out_valid.

Reset
REQ-035 While rst = 0: count = 0, both pointers = 0, in_ready = 1, out_valid = 0.
REQ-036 Buffer storage SHALL NOT be reset.
REQ-037 Reset asserted mid-operation SHALL drop all entries immediately, without waiting for a clock edge.

Structure
REQ-038 decoded_uop_t, the opcode/funct3 enums and the ALU/cmp op encodings SHALL reside in rv32i_types.
REQ-039 Decode SHALL be a combinational sub-module, inst_decoder, instantiated once on the head entry.
REQ-040 The register file SHALL remain external to this block.

Verification
REQ-041 Fill: push 4 instructions with out_ready = 0 -> count = 4, in_ready = 0; the 5th offer is not accepted.
REQ-042 Streaming: in_valid = out_ready = 1 for 20 cycles -> one uop per cycle, pc in order, count steady at 1, pointers wrap cleanly.
REQ-043 Flush with count = 3 and a push in the same cycle -> next cycle count = 0, out_valid = 0, and the pushed instruction never emerges.
REQ-044 Bypass: head is add x5,x3,x3; wb0 writes x3 = 0x11; wb1 writes x3 = 0x22 -> rs1 = rs2 = 0x22. With wb_rd_s = 0 instead -> rs values = 0.
REQ-045 Decode: sw x2,8(x1) -> rd = 0, mem_write = 1, imm = 8. srai x1,x1,3 -> imm = 3, aluop = sra. Opcode 0x7F -> illegal = 1, regf_we = 0.
REQ-046 Reset deasserted-to-asserted pulse with count = 2 -> count = 0 and out_valid = 0 before the next clock edge.
